// File: rtl/regfile_tagged.sv
// Architectural register file with a per-register busy bit and ROB tag.
// Dispatch renames mark a destination busy under a ROB tag. ROB commits write
// data and clear busy only when the committing tag still owns the register.
// A flush clears all busy state. Committed data is kept across a flush.
// Reads are combinational and forward a same-cycle commit. A same-cycle rename
// or flush is not visible on the read ports.
module regfile_tagged #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_NUM  = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned RD_PORTS = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush_in,
  input  logic                         renameE_in,
  input  logic [IDX_W-1:0]             renameIdx_in,
  input  logic [TAG_W-1:0]             renameTag_in,
  input  logic                         commitE_in,
  input  logic [IDX_W-1:0]             commitIdx_in,
  input  logic [TAG_W-1:0]             commitTag_in,
  input  logic [DATA_W-1:0]            commitData_in,
  input  logic [RD_PORTS*IDX_W-1:0]    readIdx_in,
  output logic [RD_PORTS*DATA_W-1:0]   readData_out,
  output logic [RD_PORTS-1:0]          readBusy_out,
  output logic [RD_PORTS*TAG_W-1:0]    readTag_out,
  output logic [IDX_W:0]               busyCnt_out
);

  logic [DATA_W-1:0] data_q [REG_NUM];
  logic [DATA_W-1:0] data_d [REG_NUM];
  logic [TAG_W-1:0]  tag_q  [REG_NUM];
  logic [TAG_W-1:0]  tag_d  [REG_NUM];
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic [IDX_W:0]     busyCnt_q, busyCnt_d;

  logic commit_wr;
  logic commit_clr;
  logic rename_wr;

  // Decode the qualified write strobes; x0 is never a legal destination.
  always_comb begin
    commit_wr  = commitE_in && (commitIdx_in != '0);
    commit_clr = commit_wr && busy_q[commitIdx_in] &&
                 (tag_q[commitIdx_in] == commitTag_in);
    rename_wr  = renameE_in && (renameIdx_in != '0) && !flush_in;
  end

  // Next state: commit data first, then either flush or (commit clear, then rename).
  // The rename is applied after the clear so it wins on the same index.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_wr) begin
      data_d[commitIdx_in] = commitData_in;
    end
    if (flush_in) begin
      busy_d = '0;
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end else begin
      if (commit_clr) begin
        busy_d[commitIdx_in] = 1'b0;
        tag_d[commitIdx_in]  = '0;
      end
      if (rename_wr) begin
        busy_d[renameIdx_in] = 1'b1;
        tag_d[renameIdx_in]  = renameTag_in;
      end
    end
  end

  // The busy count is the population count of the next busy vector, so it always
  // agrees with the status table after the edge.
  always_comb begin
    busyCnt_d = '0;
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      busyCnt_d = busyCnt_d + {{IDX_W{1'b0}}, busy_d[i]};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q    <= '0;
      busyCnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
      busy_q    <= busy_d;
      busyCnt_q <= busyCnt_d;
    end
  end

  assign busyCnt_out = busyCnt_q;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;
    logic [TAG_W-1:0]  rtag;

    assign idx = readIdx_in[p*IDX_W +: IDX_W];

    // Per-port read with reset/x0 forcing and same-cycle commit forwarding.
    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      rtag  = '0;
      if (rst_in || (idx == '0)) begin
        rdata = '0;
      end else if (commitE_in && (commitIdx_in == idx)) begin
        rdata = commitData_in;
        if (!commit_clr) begin
          rbusy = busy_q[idx];
          rtag  = tag_q[idx];
        end
      end else begin
        rdata = data_q[idx];
        rbusy = busy_q[idx];
        rtag  = tag_q[idx];
      end
    end

    assign readData_out[p*DATA_W +: DATA_W] = rdata;
    assign readBusy_out[p]                  = rbusy;
    assign readTag_out[p*TAG_W +: TAG_W]    = rtag;
  end

endmodule

// File: tb/tb_regfile_tagged.sv
// Self-checking bench for regfile_tagged: directed scenarios with hand-derived
// expectations, then a randomised phase checked against a behavioural model.
module tb_regfile_tagged;

  localparam int DW = 32;
  localparam int RN = 32;
  localparam int IW = 5;
  localparam int TW = 4;
  localparam int RP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, flush, ren, cen;
  logic [IW-1:0]  ridx, cidx;
  logic [TW-1:0]  rtag, ctag;
  logic [DW-1:0]  cdata;
  logic [RP*IW-1:0] rdidx;
  logic [RP*DW-1:0] rdata;
  logic [RP-1:0]    rbusy;
  logic [RP*TW-1:0] rtago;
  logic [IW:0]      cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    int          kind;   // 0 data, 1 busy, 2 tag, 3 busy count
    int          port;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  // Reference model state.
  logic [31:0] m_data [RN];
  logic        m_busy [RN];
  logic [3:0]  m_tag  [RN];
  int          m_cnt;

  regfile_tagged #(
    .DATA_W  (DW),
    .REG_NUM (RN),
    .IDX_W   (IW),
    .TAG_W   (TW),
    .RD_PORTS(RP)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .flush_in     (flush),
    .renameE_in   (ren),
    .renameIdx_in (ridx),
    .renameTag_in (rtag),
    .commitE_in   (cen),
    .commitIdx_in (cidx),
    .commitTag_in (ctag),
    .commitData_in(cdata),
    .readIdx_in   (rdidx),
    .readData_out (rdata),
    .readBusy_out (rbusy),
    .readTag_out  (rtago),
    .busyCnt_out  (cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int port);
    case (kind)
      0:       return rdata[port*DW +: DW];
      1:       return {31'b0, rbusy[port]};
      2:       return {28'b0, rtago[port*TW +: TW]};
      default: return {26'b0, cnt};
    endcase
  endfunction

  task automatic exp_rd(input string n, input int p, input logic [31:0] d,
                        input logic b, input logic [3:0] t);
    sbq.push_back('{$sformatf("%s.p%0d.data", n, p), 0, p, d});
    sbq.push_back('{$sformatf("%s.p%0d.busy", n, p), 1, p, {31'b0, b}});
    sbq.push_back('{$sformatf("%s.p%0d.tag", n, p), 2, p, {28'b0, t}});
  endtask

  task automatic exp_cnt(input string n, input int c);
    sbq.push_back('{$sformatf("%s.cnt", n), 3, 0, c});
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.name, observe(e.kind, e.port), e.exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic open_cyc();
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; ren = 1'b0; cen = 1'b0;
    ridx = '0; rtag = '0; cidx = '0; ctag = '0; cdata = '0;
  endtask

  task automatic close_cyc();
    @(negedge clk);
    drain();
  endtask

  task automatic rd(input int p, input int idx);
    rdidx[p*IW +: IW] = idx[IW-1:0];
  endtask

  task automatic do_ren(input int idx, input int tag);
    ren = 1'b1; ridx = idx[IW-1:0]; rtag = tag[TW-1:0];
  endtask

  task automatic do_com(input int idx, input int tag, input logic [31:0] d);
    cen = 1'b1; cidx = idx[IW-1:0]; ctag = tag[TW-1:0]; cdata = d;
  endtask

  task automatic model_rd(input int idx, output logic [31:0] d, output logic b,
                          output logic [3:0] t);
    d = '0; b = 1'b0; t = '0;
    if (rst || idx == 0) begin
      d = '0;
    end else if (cen && int'(cidx) == idx) begin
      d = cdata;
      if (!(m_busy[idx] && m_tag[idx] == ctag)) begin
        b = m_busy[idx];
        t = m_tag[idx];
      end
    end else begin
      d = m_data[idx];
      b = m_busy[idx];
      t = m_tag[idx];
    end
  endtask

  task automatic model_step();
    logic clr;
    if (rst) begin
      for (int i = 0; i < RN; i++) begin
        m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
      m_cnt = 0;
    end else begin
      clr = 1'b0;
      if (cen && cidx != 0) begin
        m_data[cidx] = cdata;
        clr = m_busy[cidx] && (m_tag[cidx] == ctag);
      end
      if (flush) begin
        for (int i = 0; i < RN; i++) begin
          m_busy[i] = 1'b0; m_tag[i] = '0;
        end
        m_cnt = 0;
      end else begin
        if (clr) begin
          m_busy[cidx] = 1'b0; m_tag[cidx] = '0; m_cnt--;
        end
        if (ren && ridx != 0) begin
          if (!m_busy[ridx]) m_cnt++;
          m_busy[ridx] = 1'b1; m_tag[ridx] = rtag;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        b;
    logic [3:0]  t;
    int          ix;

    rst = 1'b1; flush = 1'b0; ren = 1'b0; cen = 1'b0;
    ridx = '0; rtag = '0; cidx = '0; ctag = '0; cdata = '0; rdidx = '0;

    // Reset active: read outputs forced to zero even with a commit forwarding.
    for (int k = 0; k < 2; k++) begin
      open_cyc(); rst = 1'b1; do_com(5, 3, 32'hDEADBEEF); do_ren(6, 1);
      rd(0, 5); rd(1, 6);
      exp_rd("rst_force", 0, '0, 1'b0, '0); exp_rd("rst_force", 1, '0, 1'b0, '0);
      close_cyc();
    end

    // Post-reset sweep of every index on both ports.
    for (int i = 0; i < RN; i++) begin
      open_cyc(); rd(0, i); rd(1, RN - 1 - i);
      exp_rd($sformatf("sweep%0d", i), 0, '0, 1'b0, '0);
      exp_rd($sformatf("sweep%0d", i), 1, '0, 1'b0, '0);
      exp_cnt("sweep", 0);
      close_cyc();
    end

    // Commit forwarding on both ports, then stored value.
    open_cyc(); do_com(5, 3, 32'hDEADBEEF); rd(0, 5); rd(1, 5);
    exp_rd("c5_fwd", 0, 32'hDEADBEEF, 1'b0, '0); exp_rd("c5_fwd", 1, 32'hDEADBEEF, 1'b0, '0);
    exp_cnt("c5_fwd", 0); close_cyc();
    open_cyc(); rd(0, 5); rd(1, 0);
    exp_rd("c5_st", 0, 32'hDEADBEEF, 1'b0, '0); exp_rd("c5_st", 1, '0, 1'b0, '0); close_cyc();

    // Rename x7 tag 2, matching commit.
    open_cyc(); do_ren(7, 2); rd(0, 7); rd(1, 7);
    exp_rd("r7_same", 0, '0, 1'b0, '0); exp_rd("r7_same", 1, '0, 1'b0, '0);
    exp_cnt("r7_same", 0); close_cyc();
    open_cyc(); rd(0, 7); rd(1, 5);
    exp_rd("r7_busy", 0, '0, 1'b1, 4'd2); exp_rd("r7_busy", 1, 32'hDEADBEEF, 1'b0, '0);
    exp_cnt("r7_busy", 1); close_cyc();
    open_cyc(); do_com(7, 2, 32'h11); rd(0, 7); rd(1, 7);
    exp_rd("c7_fwd", 0, 32'h11, 1'b0, '0); exp_rd("c7_fwd", 1, 32'h11, 1'b0, '0);
    exp_cnt("c7_fwd", 1); close_cyc();
    open_cyc(); rd(0, 7); rd(1, 7);
    exp_rd("c7_st", 0, 32'h11, 1'b0, '0); exp_cnt("c7_st", 0); close_cyc();

    // Stale commit must not clear a younger rename.
    open_cyc(); do_ren(7, 2); rd(0, 7); rd(1, 7);
    exp_rd("rr_a", 0, 32'h11, 1'b0, '0); exp_cnt("rr_a", 0); close_cyc();
    open_cyc(); do_ren(7, 9); rd(0, 7); rd(1, 7);
    exp_rd("rr_b", 1, 32'h11, 1'b1, 4'd2); exp_cnt("rr_b", 1); close_cyc();
    open_cyc(); do_com(7, 2, 32'h22); rd(0, 7); rd(1, 7);
    exp_rd("stale", 0, 32'h22, 1'b1, 4'd9); exp_cnt("stale", 1); close_cyc();
    open_cyc(); rd(0, 7); rd(1, 7);
    exp_rd("stale_st", 1, 32'h22, 1'b1, 4'd9); exp_cnt("stale_st", 1); close_cyc();
    open_cyc(); do_com(7, 9, 32'h33); rd(0, 7); rd(1, 7);
    exp_rd("young", 0, 32'h33, 1'b0, '0); exp_cnt("young", 1); close_cyc();
    open_cyc(); rd(0, 7); rd(1, 7);
    exp_rd("young_st", 0, 32'h33, 1'b0, '0); exp_cnt("young_st", 0); close_cyc();

    // Three renames then flush with same-cycle rename and commit.
    open_cyc(); do_ren(3, 1); close_cyc();
    open_cyc(); do_ren(4, 5); close_cyc();
    open_cyc(); do_ren(6, 6); rd(0, 3); rd(1, 4);
    exp_rd("pre_fl", 0, '0, 1'b1, 4'd1); exp_rd("pre_fl", 1, '0, 1'b1, 4'd5);
    exp_cnt("pre_fl", 2); close_cyc();
    open_cyc(); flush = 1'b1; do_ren(8, 7); do_com(3, 1, 32'hABCD); rd(0, 3); rd(1, 6);
    exp_rd("fl_same", 0, 32'hABCD, 1'b0, '0); exp_rd("fl_same", 1, '0, 1'b1, 4'd6);
    exp_cnt("fl_same", 3); close_cyc();
    open_cyc(); rd(0, 4); rd(1, 8);
    exp_rd("fl_after", 0, '0, 1'b0, '0); exp_rd("fl_after", 1, '0, 1'b0, '0);
    exp_cnt("fl_after", 0); close_cyc();
    open_cyc(); rd(0, 3); rd(1, 6);
    exp_rd("fl_data", 0, 32'hABCD, 1'b0, '0); exp_rd("fl_data", 1, '0, 1'b0, '0); close_cyc();

    // Rename and matching commit on the same index: rename wins, count net zero.
    open_cyc(); do_ren(9, 4); close_cyc();
    open_cyc(); do_ren(9, 10); do_com(9, 4, 32'h55); rd(0, 9); rd(1, 9);
    exp_rd("rc_same", 0, 32'h55, 1'b0, '0); exp_cnt("rc_same", 1); close_cyc();
    open_cyc(); rd(0, 9); rd(1, 9);
    exp_rd("rc_after", 0, 32'h55, 1'b1, 4'd10); exp_rd("rc_after", 1, 32'h55, 1'b1, 4'd10);
    exp_cnt("rc_after", 1); close_cyc();

    // x0 is never written or busy.
    open_cyc(); do_ren(0, 3); do_com(0, 3, 32'hFFFFFFFF); rd(0, 0); rd(1, 0);
    exp_rd("x0_same", 0, '0, 1'b0, '0); exp_rd("x0_same", 1, '0, 1'b0, '0);
    exp_cnt("x0_same", 1); close_cyc();
    open_cyc(); rd(0, 0); rd(1, 0);
    exp_rd("x0_after", 0, '0, 1'b0, '0); exp_cnt("x0_after", 1); close_cyc();

    // Reset mid-sequence with busy registers.
    open_cyc(); do_ren(10, 2); close_cyc();
    open_cyc(); rst = 1'b1; do_ren(11, 5); rd(0, 9); rd(1, 10);
    exp_rd("mid_rst", 0, '0, 1'b0, '0); exp_rd("mid_rst", 1, '0, 1'b0, '0); close_cyc();
    open_cyc(); rd(0, 9); rd(1, 11);
    exp_rd("post_rst", 0, '0, 1'b0, '0); exp_rd("post_rst", 1, '0, 1'b0, '0);
    exp_cnt("post_rst", 0); close_cyc();
    open_cyc(); rd(0, 10); rd(1, 3);
    exp_rd("post_rst2", 0, '0, 1'b0, '0); exp_rd("post_rst2", 1, '0, 1'b0, '0);
    exp_cnt("post_rst2", 0); close_cyc();

    // Randomised phase over a small index range to force collisions.
    for (int i = 0; i < 400; i++) begin
      open_cyc();
      rst   = (i == 0) || ($urandom_range(63) == 0);
      flush = ($urandom_range(15) == 0);
      if ($urandom_range(1) == 1) do_ren($urandom_range(7), $urandom_range(15));
      if ($urandom_range(1) == 1) begin
        ix = $urandom_range(7);
        do_com(ix, ($urandom_range(3) != 0 && i > 0) ? int'(m_tag[ix]) : $urandom_range(15),
               $urandom);
      end
      for (int p = 0; p < RP; p++) begin
        ix = $urandom_range(7);
        rd(p, ix);
        if (i > 0) begin
          model_rd(ix, d, b, t);
          exp_rd($sformatf("rnd%0d", i), p, d, b, t);
        end
      end
      if (i > 0 && !rst) exp_cnt($sformatf("rnd%0d", i), m_cnt);
      close_cyc();
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
